prog_counter: RTL

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_step.sv | 46 ++++
 rtl/prog_counter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the programmable counter: mode selectors and one-shot FSM states.
package counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value arithmetic: +/-1 step, boundary detection with
// wrap or hold, and clamping of the load value to the terminal value.
module counter_step #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_count,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] step_val,
  output logic             boundary,
  output logic [WIDTH-1:0] load_clamped
);

  // step value and boundary detect for the current direction
  always_comb begin
    step_val = count;
    boundary = 1'b0;
    if (up_count) begin
      boundary = (count == MAX_VAL);
      if (boundary) begin
        step_val = hold ? count : '0;
      end else begin
        step_val = count + WIDTH'(1);
      end
    end else begin
      boundary = (count == '0);
      if (boundary) begin
        step_val = hold ? count : MAX_VAL;
      end else begin
        step_val = count - WIDTH'(1);
      end
    end
  end

  // clamp load value into 0..MAX_VAL
  always_comb begin
    if (load_val > MAX_VAL) begin
      load_clamped = MAX_VAL;
    end else begin
      load_clamped = load_val;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes,
// registered count, terminal-count pulse, sticky boundary flag and busy.
module prog_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter int              MODE    = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_count,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("prog_counter: WIDTH must be 1..32");
  end
  if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("prog_counter: MAX_VAL must be 1..2**WIDTH-1");
  end
  if (MODE != MODE_WRAP && MODE != MODE_SAT && MODE != MODE_ONESHOT) begin : g_bad_mode
    $error("prog_counter: unknown MODE");
  end

  localparam logic [WIDTH-1:0] MAX_C  = MAX_VAL[WIDTH-1:0];
  localparam logic             HOLD_C = (MODE != MODE_WRAP);

  logic [WIDTH-1:0] count_r, count_next_s, step_val_s, load_clamped_s;
  logic             tc_r, tc_next_s, ovf_r, ovf_next_s, busy_r, boundary_s;
  state_e           state_r, state_next_s;

  counter_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_C)) u_step (
    .count        (count_r),
    .up_count     (up_count),
    .hold         (HOLD_C),
    .load_val     (load_val),
    .step_val     (step_val_s),
    .boundary     (boundary_s),
    .load_clamped (load_clamped_s)
  );

  // next-state and next-output selection: load beats counting, rst handled in the register
  always_comb begin
    count_next_s = count_r;
    tc_next_s    = 1'b0;
    ovf_next_s   = ovf_r;
    state_next_s = state_r;
    if (load) begin
      count_next_s = load_clamped_s;
      ovf_next_s   = 1'b0;
      state_next_s = ST_IDLE;
    end else if (MODE == MODE_ONESHOT) begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_next_s = ST_RUN;
            count_next_s = up_count ? '0 : MAX_C;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (en) begin
            count_next_s = step_val_s;
            if (boundary_s) begin
              tc_next_s    = 1'b1;
              ovf_next_s   = 1'b1;
              state_next_s = ST_DONE;
            end else begin
              state_next_s = ST_RUN;
            end
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_DONE: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end else if (en) begin
      count_next_s = step_val_s;
      if (boundary_s) begin
        tc_next_s  = 1'b1;
        ovf_next_s = 1'b1;
      end else begin
        tc_next_s  = 1'b0;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      state_r <= ST_IDLE;
    end else begin
      count_r <= count_next_s;
      tc_r    <= tc_next_s;
      ovf_r   <= ovf_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      state_r <= state_next_s;
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign ovf   = ovf_r;
  assign busy  = busy_r;

endmodule
